// File: rtl/armleosoc_axi2simple_burst_converter_pkg.sv
// Shared AXI encodings, response codes and converter state encoding.
// Also holds the request legality check used on every AR/AW accept.
package armleosoc_axi2simple_burst_converter_pkg;

  localparam logic [1:0] BURST_FIXED    = 2'b00;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] BURST_WRAP     = 2'b10;
  localparam logic [1:0] BURST_RESERVED = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE_DATA,
    ST_WRITE_RESP
  } state_t;

  // Only full-width, size-aligned beats with a legal burst type/WRAP length are served.
  function automatic logic burst_illegal(input logic [2:0] size,
                                         input logic [2:0] size_log,
                                         input logic [7:0] len,
                                         input logic [1:0] burst,
                                         input logic [7:0] addr_lo);
    logic [7:0] align_mask;
    align_mask = (8'd1 << size) - 8'd1;
    return (size != size_log) ||
           (burst == BURST_RESERVED) ||
           ((addr_lo & align_mask) != 8'd0) ||
           ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

endpackage

// File: rtl/armleosoc_axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module armleosoc_axi_burst_addr_gen
  import armleosoc_axi2simple_burst_converter_pkg::*;
#(
  parameter int ADDR_WIDTH = 34
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // WRAP lengths are powers of two, so the window is a simple low-bit mask.
  always_comb begin
    beat_bytes = ADDR_WIDTH'(1) << size;
    incr_addr  = addr + beat_bytes;
    wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/armleosoc_axi2simple_burst_converter.sv
// AXI4 subordinate that splits FIXED/INCR/WRAP bursts into single-beat
// accesses on the simple register interface, one beat per cycle.
module armleosoc_axi2simple_burst_converter
  import armleosoc_axi2simple_burst_converter_pkg::*;
#(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic                    axi_awlock,
  input  logic [3:0]              axi_awcache,
  input  logic [2:0]              axi_awprot,
  input  logic [3:0]              axi_awqos,
  input  logic [3:0]              axi_awregion,

  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,

  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  output logic [1:0]              axi_bresp,
  output logic [ID_WIDTH-1:0]     axi_bid,

  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic                    axi_arlock,
  input  logic [3:0]              axi_arcache,
  input  logic [2:0]              axi_arprot,
  input  logic [3:0]              axi_arqos,
  input  logic [3:0]              axi_arregion,

  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic [ID_WIDTH-1:0]     axi_rid,

  input  logic                    address_error,
  input  logic                    write_error,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    write,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH/8-1:0] write_byteenable,
  output logic                    read,
  input  logic [DATA_WIDTH-1:0]   read_data
);

  localparam logic [2:0] SIZE_LOG = 3'($clog2(DATA_WIDTH / 8));

  state_t                state, state_nxt;
  logic                  last_grant_write;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [7:0]            len_q, beat_cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;
  logic                  issued_all;

  logic                  rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q, bresp_q;
  logic [ID_WIDTH-1:0]   rid_q;

  logic                  grant_write, grant_read, ar_hs, aw_hs;
  logic                  last_beat, beat_issue, w_beat;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_len;
  logic [2:0]            req_size;
  logic [1:0]            req_burst;
  logic [ID_WIDTH-1:0]   req_id;
  logic [1:0]            r_resp, w_resp;
  logic                  unused_ok;

  assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awregion,
                       axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion};

  // 1-bit round robin: on contention the channel not granted last time wins.
  assign grant_write = axi_awvalid && (!axi_arvalid || !last_grant_write);
  assign grant_read  = axi_arvalid && !grant_write;
  assign ar_hs       = axi_arvalid && axi_arready;
  assign aw_hs       = axi_awvalid && axi_awready;

  assign req_addr  = grant_write ? axi_awaddr  : axi_araddr;
  assign req_len   = grant_write ? axi_awlen   : axi_arlen;
  assign req_size  = grant_write ? axi_awsize  : axi_arsize;
  assign req_burst = grant_write ? axi_awburst : axi_arburst;
  assign req_id    = grant_write ? axi_awid    : axi_arid;

  assign last_beat  = (beat_cnt == len_q);
  assign beat_issue = (state == ST_READ) && !issued_all && (!rvalid_q || axi_rready);
  assign w_beat     = (state == ST_WRITE_DATA) && axi_wvalid;

  assign r_resp = err_q         ? RESP_SLVERR :
                  address_error ? RESP_DECERR : RESP_OKAY;
  assign w_resp = err_q                                 ? RESP_SLVERR :
                  address_error                         ? RESP_DECERR :
                  (write_error || (axi_wlast != last_beat)) ? RESP_SLVERR : RESP_OKAY;

  armleosoc_axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_write)     state_nxt = ST_WRITE_DATA;
        else if (grant_read) state_nxt = ST_READ;
      end
      ST_READ:       if (rvalid_q && axi_rready && rlast_q) state_nxt = ST_IDLE;
      ST_WRITE_DATA: if (w_beat && last_beat)               state_nxt = ST_WRITE_RESP;
      ST_WRITE_RESP: if (axi_bready)                        state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = (state == ST_IDLE) && grant_read && !rst;
    axi_awready = (state == ST_IDLE) && grant_write && !rst;
    axi_wready  = (state == ST_WRITE_DATA);
    axi_bvalid  = (state == ST_WRITE_RESP);
    read        = beat_issue && !err_q;
    write       = w_beat && !err_q;
  end

  // Request latch, beat advance and the registered R stage share one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_write <= 1'b0;
      addr_q           <= '0;
      len_q            <= '0;
      size_q           <= '0;
      burst_q          <= '0;
      id_q             <= '0;
      beat_cnt         <= '0;
      err_q            <= 1'b0;
      issued_all       <= 1'b0;
      rvalid_q         <= 1'b0;
      rlast_q          <= 1'b0;
      rdata_q          <= '0;
      rresp_q          <= RESP_OKAY;
      rid_q            <= '0;
      bresp_q          <= RESP_OKAY;
    end else begin
      if (ar_hs || aw_hs) begin
        last_grant_write <= aw_hs;
        addr_q           <= req_addr;
        len_q            <= req_len;
        size_q           <= req_size;
        burst_q          <= req_burst;
        id_q             <= req_id;
        beat_cnt         <= '0;
        err_q            <= burst_illegal(req_size, SIZE_LOG, req_len, req_burst, req_addr[7:0]);
        issued_all       <= 1'b0;
        if (aw_hs) bresp_q <= RESP_OKAY;
      end
      if (beat_issue) begin
        rvalid_q <= 1'b1;
        rdata_q  <= err_q ? '0 : read_data;
        rresp_q  <= r_resp;
        rlast_q  <= last_beat;
        rid_q    <= id_q;
        addr_q   <= addr_nxt;
        beat_cnt <= beat_cnt + 8'd1;
        if (last_beat) issued_all <= 1'b1;
      end else if (rvalid_q && axi_rready) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
      if (w_beat) begin
        addr_q   <= addr_nxt;
        beat_cnt <= beat_cnt + 8'd1;
        bresp_q  <= (w_resp > bresp_q) ? w_resp : bresp_q;
      end
    end
  end

  assign axi_rvalid       = rvalid_q;
  assign axi_rdata        = rdata_q;
  assign axi_rresp        = rresp_q;
  assign axi_rlast        = rlast_q;
  assign axi_rid          = rid_q;
  assign axi_bresp        = bresp_q;
  assign axi_bid          = id_q;
  assign address          = addr_q;
  assign write_data       = axi_wdata;
  assign write_byteenable = axi_wstrb;

endmodule
